conv_output_collector: RTL and testbench
========================================

CONV_OUTPUT_COLLECTOR -- requirements
Module: conv_output_collector

Interface
REQ-001 SHALL have parameter BIN_LEN, default 8: width of the requantized output word.
REQ-002 SHALL have parameter OUT_BIN_LEN, default 16: width of the incoming partial-sum result.
REQ-003 SHALL have parameters INPUT_WIDTH=8, INPUT_HEIGHT=8, KERNEL_WIDTH=3, KERNEL_HEIGHT=3: feature-map and kernel dimensions.
REQ-004 SHALL have parameter FIFO_DEPTH, default 4 (power of 2): result buffer depth.
REQ-005 SHALL have parameter ADDR_W, default 6: write address width, ≥ clog2(OUT_W*OUT_H), where OUT_W=INPUT_WIDTH-KERNEL_WIDTH+1 and OUT_H=INPUT_HEIGHT-KERNEL_HEIGHT+1.
REQ-006 clock  input  1  rising-edge clock.
REQ-007 reset  input  1  synchronous, active-high.
REQ-008 start  input  1  one-cycle pulse that begins a frame.
REQ-009 shift  input  4  requantization right-shift amount, captured on start.
REQ-010 output_val  input  OUT_BIN_LEN  unsigned convolution result from the processing unit.
REQ-011 output_valid  input  1  output_val valid this cycle; no back-pressure is possible.
REQ-012 pu_done  input  1  processing unit finished the frame (one-cycle pulse).
REQ-013 wr_valid  output  1  write request to the output memory.
REQ-014 wr_addr  output  ADDR_W  linear address, row*OUT_W+col.
REQ-015 wr_data  output  BIN_LEN  requantized result.
REQ-016 wr_ready  input  1  memory accepts the write when wr_valid&&wr_ready.
REQ-017 done  output  1  one-cycle pulse when the frame is fully written.
REQ-018 overflow  output  1  sticky flag: a result was dropped because the FIFO was full.
REQ-019 count_err  output  1  sticky flag: the result count differs from OUT_W*OUT_H.

Function
REQ-020 FSM states SHALL be IDLE, RUN, DRAIN and DONE; the FSM SHALL reset to IDLE.
REQ-021 IDLE->RUN on start; on that edge the block SHALL clear the FIFO, the address counter, the result counter, overflow and count_err, and SHALL latch shift.
REQ-022 start SHALL be ignored outside IDLE.
REQ-023 RUN->DRAIN SHALL occur on pu_done; an output_valid in the same cycle SHALL still be pushed.
REQ-024 DRAIN->DONE SHALL occur when the FIFO is empty and no write is pending.
REQ-025 DONE SHALL assert done for exactly one cycle, then move to IDLE.
REQ-026 Requantization: q = output_val >> shift_reg; wr_data = (q > 2^BIN_LEN-1) ? all-ones : q[BIN_LEN-1:0].
REQ-027 Requantization SHALL be applied at push time, and the FIFO SHALL store BIN_LEN-bit words.
REQ-028 An output_valid in RUN SHALL push, and SHALL increment the result counter, which saturates at its maximum.
REQ-029 An output_valid in IDLE, DRAIN or DONE SHALL be ignored.
REQ-030 A push when the FIFO is full and no pop occurs in the same cycle SHALL drop the word and set overflow.
REQ-031 A push and a pop in the same cycle when the FIFO is full SHALL both succeed.
REQ-032 A push beyond result index OUT_W*OUT_H-1 SHALL be dropped and SHALL set count_err.
REQ-033 The FIFO SHALL be first-word-fall-through: wr_valid = !empty, and wr_data is the head word.
REQ-034 Minimum latency from output_valid to wr_valid SHALL be one cycle (registered push).
REQ-035 wr_valid, wr_addr and wr_data SHALL stay stable until wr_ready.
REQ-036 A pop SHALL occur on wr_valid&&wr_ready, and SHALL advance wr_addr by 1.
REQ-037 On entry to DONE, count_err SHALL be set if the result count is not equal to OUT_W*OUT_H.
REQ-038 overflow and count_err SHALL hold until the next accepted start or reset.

Reset
REQ-039 While reset is high at an edge, the FSM SHALL go to IDLE and the FIFO pointers and count SHALL be cleared.
REQ-040 While reset is high at an edge, wr_valid, wr_addr, done, overflow, count_err and shift_reg SHALL become 0.
REQ-041 Reset mid-frame SHALL abort the frame: no further wr_valid, and no done pulse.

Verification
REQ-042 Nominal frame: shift=2, 36 pulses with output_val=0x0234, wr_ready=1 -> 36 writes, data 0x8D at addresses 0..35, done one cycle after the last write, no flags set.
REQ-043 Saturation: shift=2, output_val=0x1000 -> wr_data=0xFF; shift=0, output_val=0x00FF -> 0xFF; shift=15, output_val=0xFFFF -> 0x01.
REQ-044 Back-pressure: wr_ready=0 for 4 results, then output_valid on 5th -> 5th dropped, overflow=1, first 4 words written in order once wr_ready=1; count_err=1 at done.
REQ-045 Simultaneous events: FIFO full, output_valid and wr_ready high in one cycle -> no drop; also pu_done in the same cycle as the last output_valid -> that word is written before done.
REQ-046 Short frame: 35 results then pu_done -> 35 writes (addresses 0..34), done pulses, count_err=1; a second start then clears the flags.
REQ-047 Reset after 10 results with wr_ready=0 -> wr_valid=0 next cycle, no done, next start writes from address 0.

Source files
------------

// File: rtl/conv_output_collector.sv
// conv_output_collector: requantizes convolution results, buffers them and writes them to output memory
module conv_output_collector #(
    parameter int BIN_LEN       = 8,
    parameter int OUT_BIN_LEN   = 16,
    parameter int INPUT_WIDTH   = 8,
    parameter int INPUT_HEIGHT  = 8,
    parameter int KERNEL_WIDTH  = 3,
    parameter int KERNEL_HEIGHT = 3,
    parameter int FIFO_DEPTH    = 4,
    parameter int ADDR_W        = 6
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   start,
    input  logic [3:0]             shift,
    input  logic [OUT_BIN_LEN-1:0] output_val,
    input  logic                   output_valid,
    input  logic                   pu_done,
    output logic                   wr_valid,
    output logic [ADDR_W-1:0]      wr_addr,
    output logic [BIN_LEN-1:0]     wr_data,
    input  logic                   wr_ready,
    output logic                   done,
    output logic                   overflow,
    output logic                   count_err
);
    localparam int OUT_W = INPUT_WIDTH - KERNEL_WIDTH + 1;
    localparam int OUT_H = INPUT_HEIGHT - KERNEL_HEIGHT + 1;
    localparam int TOTAL = OUT_W * OUT_H;
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = ADDR_W + 1;
    localparam logic [1:0] IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2, DONE = 2'd3;

    logic [1:0]             state;
    logic [3:0]             shift_reg;
    logic [BIN_LEN-1:0]     mem [FIFO_DEPTH];
    logic [PTR_W-1:0]       rd_ptr, wr_ptr;
    logic [PTR_W:0]         fill;
    logic [CNT_W-1:0]       res_cnt;
    logic [OUT_BIN_LEN-1:0] q;
    logic [BIN_LEN-1:0]     q_sat;
    logic                   full, in_push, room, pop, push, begin_frame;

    // Requantize the incoming result and decide push/pop/drop for this cycle
    always_comb begin
        q           = output_val >> shift_reg;
        q_sat       = |(q >> BIN_LEN) ? '1 : q[BIN_LEN-1:0];
        full        = fill == (PTR_W+1)'(FIFO_DEPTH);
        wr_valid    = fill != '0;
        wr_data     = mem[rd_ptr];
        done        = state == DONE;
        begin_frame = state == IDLE && start;
        in_push     = state == RUN && output_valid;
        room        = res_cnt < CNT_W'(TOTAL);
        pop         = wr_valid && wr_ready;
        push        = in_push && room && (!full || pop);
    end

    // FIFO storage holds already-requantized words
    always_ff @(posedge clock) begin
        if (push && !begin_frame) mem[wr_ptr] <= q_sat;
    end

    // Frame control, FIFO bookkeeping, address/result counters and sticky flags
    always_ff @(posedge clock) begin
        if (reset || begin_frame) begin
            state     <= reset ? IDLE : RUN;
            shift_reg <= reset ? 4'd0 : shift;
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            fill      <= '0;
            wr_addr   <= '0;
            res_cnt   <= '0;
            overflow  <= 1'b0;
            count_err <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) begin
                rd_ptr  <= rd_ptr + 1'b1;
                wr_addr <= wr_addr + 1'b1;
            end
            fill <= fill + (PTR_W+1)'(push) - (PTR_W+1)'(pop);
            if (in_push && res_cnt != '1) res_cnt <= res_cnt + 1'b1;
            if (in_push && !room) count_err <= 1'b1;
            if (in_push && room && full && !pop) overflow <= 1'b1;
            if (state == RUN && pu_done) state <= DRAIN;
            else if (state == DRAIN && !wr_valid) begin
                state <= DONE;
                if (res_cnt != CNT_W'(TOTAL)) count_err <= 1'b1;
            end else if (state == DONE) state <= IDLE;
        end
    end
endmodule

// File: tb/tb_conv_output_collector.sv
// tb_conv_output_collector: randomized and directed checks against a queue-based reference model
module tb_conv_output_collector;
    logic        clock = 0, reset = 1, start = 0, output_valid = 0, pu_done = 0, wr_ready = 0;
    logic [3:0]  shift = 0;
    logic [15:0] output_val = 0;
    logic        wr_valid, done, overflow, count_err;
    logic [5:0]  wr_addr;
    logic [7:0]  wr_data;
    int checks = 0, errors = 0;
    bit mon_en = 0;

    conv_output_collector dut (
        .clock(clock), .reset(reset), .start(start), .shift(shift),
        .output_val(output_val), .output_valid(output_valid), .pu_done(pu_done),
        .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(wr_ready),
        .done(done), .overflow(overflow), .count_err(count_err)
    );

    always #5 clock = ~clock;

    // Reference model: a bounded queue of expected words plus frame phase and flags
    logic [7:0]  m_q[$];
    int          m_phase = 0, m_addr = 0, m_cnt = 0, m_pre;
    bit          m_ovf = 0, m_cerr = 0, m_pop;
    logic [3:0]  m_shift = 0;
    logic [15:0] m_v;
    always @(posedge clock) begin
        m_pre = m_q.size();
        m_pop = m_pre > 0 && wr_ready;
        if (reset) begin
            m_q.delete(); m_phase = 0; m_addr = 0; m_cnt = 0; m_ovf = 0; m_cerr = 0; m_shift = 0;
        end else if (m_phase == 0 && start) begin
            m_q.delete(); m_phase = 1; m_addr = 0; m_cnt = 0; m_ovf = 0; m_cerr = 0; m_shift = shift;
        end else begin
            if (m_pop) begin void'(m_q.pop_front()); m_addr++; end
            if (m_phase == 1 && output_valid) begin
                if (m_cnt >= 36) m_cerr = 1;
                else if (m_pre == 4 && !m_pop) m_ovf = 1;
                else begin
                    m_v = output_val >> m_shift;
                    m_q.push_back(m_v > 16'd255 ? 8'hFF : m_v[7:0]);
                end
                m_cnt++;
            end
            if (m_phase == 1 && pu_done) m_phase = 2;
            else if (m_phase == 2 && m_pre == 0) begin m_phase = 3; if (m_cnt != 36) m_cerr = 1; end
            else if (m_phase == 3) m_phase = 0;
        end
    end

    // Scoreboard: compare every cycle against the model and log accepted writes
    logic [7:0] wlog[$];
    int         alog[$];
    always @(negedge clock) begin
        if (mon_en) begin
            checks++;
            if (wr_valid !== (m_q.size() != 0)) begin errors++; $display("FAIL sb_valid got %b exp %b", wr_valid, m_q.size() != 0); end
            if (wr_valid === 1'b1 && m_q.size() != 0) begin
                checks += 2;
                if (wr_addr !== 6'(m_addr)) begin errors++; $display("FAIL sb_addr got %0d exp %0d", wr_addr, m_addr); end
                if (wr_data !== m_q[0]) begin errors++; $display("FAIL sb_data got %h exp %h", wr_data, m_q[0]); end
            end
            checks += 3;
            if (done !== (m_phase == 3)) begin errors++; $display("FAIL sb_done got %b exp %b", done, m_phase == 3); end
            if (overflow !== m_ovf) begin errors++; $display("FAIL sb_overflow got %b exp %b", overflow, m_ovf); end
            if (count_err !== m_cerr) begin errors++; $display("FAIL sb_count_err got %b exp %b", count_err, m_cerr); end
            if (wr_valid === 1'b1 && wr_ready) begin wlog.push_back(wr_data); alog.push_back(int'(wr_addr)); end
        end
    end

    task automatic tick();
        @(posedge clock); #1;
    endtask

    task automatic begin_frame(input logic [3:0] s);
        wlog.delete(); alog.delete();
        start = 1; shift = s; tick(); start = 0;
    endtask

    task automatic push(input logic [15:0] v, input bit last);
        output_val = v; output_valid = 1; pu_done = last; tick();
        output_valid = 0; pu_done = 0;
    endtask

    task automatic end_frame();
        pu_done = 1; tick(); pu_done = 0;
    endtask

    task automatic wait_done(output bit ok);
        ok = 0;
        for (int i = 0; i < 500 && !ok; i++) begin
            if (done === 1'b1) ok = 1;
            tick();
        end
    endtask

    task automatic test_reset();
        reset = 1; tick(); tick(); reset = 0; mon_en = 1;
        checks++;
        if ({wr_valid, wr_addr, done, overflow, count_err} !== 10'd0) begin
            errors++; $display("FAIL reset_state got %b exp 0", {wr_valid, wr_addr, done, overflow, count_err});
        end
    endtask

    task automatic test_nominal();
        bit ok; int bad = 0;
        wr_ready = 1; begin_frame(2);
        for (int i = 0; i < 36; i++) push(16'h0234, 0);
        end_frame(); wait_done(ok);
        foreach (wlog[i]) if (wlog[i] !== 8'h8D || alog[i] != i) bad++;
        checks += 4;
        if (!ok) begin errors++; $display("FAIL nominal_done got 0 exp 1"); end
        if (wlog.size() != 36) begin errors++; $display("FAIL nominal_writes got %0d exp 36", wlog.size()); end
        if (bad != 0) begin errors++; $display("FAIL nominal_data bad words %0d exp 0", bad); end
        if ({overflow, count_err} !== 2'b00) begin errors++; $display("FAIL nominal_flags got %b exp 00", {overflow, count_err}); end
    endtask

    task automatic test_saturation();
        logic [3:0]  s[3] = '{4'd2, 4'd0, 4'd15};
        logic [15:0] v[3] = '{16'h1000, 16'h00FF, 16'hFFFF};
        logic [7:0]  e[3] = '{8'hFF, 8'hFF, 8'h01};
        bit ok;
        for (int k = 0; k < 3; k++) begin
            wr_ready = 1; begin_frame(s[k]); push(v[k], 1); wait_done(ok);
            checks++;
            if (!ok || wlog.size() != 1 || wlog[0] !== e[k])
                begin errors++; $display("FAIL saturation_%0d got %h (n=%0d) exp %h", k, wlog[0], wlog.size(), e[k]); end
        end
    endtask

    task automatic test_back_pressure();
        bit ok; int bad = 0;
        wr_ready = 0; begin_frame(4);
        for (int i = 0; i < 5; i++) push(16'((i + 1) << 4), 0);
        checks += 2;
        if (overflow !== 1'b1) begin errors++; $display("FAIL bp_overflow got %b exp 1", overflow); end
        if (wr_valid !== 1'b1 || wr_data !== 8'h01) begin errors++; $display("FAIL bp_hold got %b/%h exp 1/01", wr_valid, wr_data); end
        end_frame(); wr_ready = 1; wait_done(ok);
        foreach (wlog[i]) if (wlog[i] !== 8'(i + 1)) bad++;
        checks += 2;
        if (!ok || wlog.size() != 4 || bad != 0) begin errors++; $display("FAIL bp_writes got n=%0d bad=%0d exp n=4 bad=0", wlog.size(), bad); end
        if (count_err !== 1'b1) begin errors++; $display("FAIL bp_count_err got %b exp 1", count_err); end
    endtask

    task automatic test_back_to_back();
        bit ok; int bad = 0;
        wr_ready = 0; begin_frame(4);
        for (int i = 0; i < 4; i++) push(16'((i + 1) << 4), 0);
        wr_ready = 1; push(16'h0050, 1);
        checks++;
        if (overflow !== 1'b0) begin errors++; $display("FAIL b2b_overflow got %b exp 0", overflow); end
        wait_done(ok);
        foreach (wlog[i]) if (wlog[i] !== 8'(i + 1)) bad++;
        checks++;
        if (!ok || wlog.size() != 5 || bad != 0) begin errors++; $display("FAIL b2b_writes got n=%0d bad=%0d exp n=5 bad=0", wlog.size(), bad); end
    endtask

    task automatic test_short_frame();
        bit ok;
        wr_ready = 1; begin_frame(2);
        for (int i = 0; i < 35; i++) push(16'(i * 8), 0);
        end_frame(); wait_done(ok);
        checks += 2;
        if (!ok || wlog.size() != 35 || alog[34] != 34) begin errors++; $display("FAIL short_writes got n=%0d exp 35", wlog.size()); end
        if (count_err !== 1'b1) begin errors++; $display("FAIL short_count_err got %b exp 1", count_err); end
        begin_frame(1);
        checks++;
        if ({overflow, count_err} !== 2'b00) begin errors++; $display("FAIL short_restart_flags got %b exp 00", {overflow, count_err}); end
        end_frame(); wait_done(ok);
    endtask

    task automatic test_reset_mid();
        bit ok, seen = 0;
        wr_ready = 0; begin_frame(1);
        for (int i = 0; i < 10; i++) push(16'h0100, 0);
        reset = 1; tick(); reset = 0;
        checks++;
        if (wr_valid !== 1'b0) begin errors++; $display("FAIL mid_reset_valid got %b exp 0", wr_valid); end
        for (int i = 0; i < 20; i++) begin if (done === 1'b1) seen = 1; tick(); end
        checks++;
        if (seen) begin errors++; $display("FAIL mid_reset_done got 1 exp 0"); end
        wr_ready = 1; begin_frame(0); push(16'h0012, 1); wait_done(ok);
        checks++;
        if (!ok || wlog.size() != 1 || alog[0] != 0 || wlog[0] !== 8'h12)
            begin errors++; $display("FAIL mid_reset_restart got n=%0d addr=%0d exp n=1 addr=0", wlog.size(), alog[0]); end
    endtask

    task automatic test_random();
        bit ok; int n;
        for (int f = 0; f < 6; f++) begin
            n = $urandom_range(30, 40);
            wr_ready = 1; begin_frame(4'($urandom_range(0, 15)));
            for (int i = 0; i < n; i++) begin
                repeat ($urandom_range(0, 2)) begin wr_ready = ($urandom % 4) != 0; tick(); end
                wr_ready = ($urandom % 4) != 0;
                push(16'($urandom), i == n - 1 && f[0]);
            end
            if (!f[0]) end_frame();
            wr_ready = 1; wait_done(ok);
            checks += 2;
            if (!ok) begin errors++; $display("FAIL random_done frame %0d got 0 exp 1", f); end
            if (count_err !== (n != 36)) begin errors++; $display("FAIL random_count_err frame %0d got %b exp %b", f, count_err, n != 36); end
        end
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_saturation();
        test_back_pressure();
        test_back_to_back();
        test_short_frame();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end
endmodule
